// File: rtl/cnn_pixel_streamer_pkg.sv
// Shared types and sizing for the CNN pixel streamer: pixel format, frame size
// and read-side FSM states.
package cnn_stream_pkg;
  localparam int BIT_W  = 4;
  localparam int FRAC_W = 2;
  localparam int IN_W   = 8;
  localparam int NPIX   = IN_W * IN_W;

  typedef logic signed [BIT_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } stream_state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cnn_pixel_streamer_if.sv
// Write-port handshake and CNN-facing pixel stream of the pixel streamer.
interface cnn_pixel_streamer_if #(
  parameter int bitWidth = cnn_stream_pkg::BIT_W
);
  logic                       wrValid;
  logic                       wrReady;
  logic signed [bitWidth-1:0] wrPixel;
  logic                       wrLast;
  logic signed [bitWidth-1:0] outPixel;
  logic                       outValid;
  logic                       outFirst;
  logic                       outLast;

  modport master (
    output wrValid, wrPixel, wrLast,
    input  wrReady, outPixel, outValid, outFirst, outLast
  );

  modport slave (
    input  wrValid, wrPixel, wrLast,
    output wrReady, outPixel, outValid, outFirst, outLast
  );
endinterface

// File: rtl/cnn_pixel_streamer_bank.sv
// One frame buffer: DEPTH-entry register file, synchronous write and
// combinational read. Contents are intentionally not reset.
module pixel_bank #(
  parameter int bitWidth = 4,
  parameter int DEPTH    = 64,
  parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [bitWidth-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [bitWidth-1:0] o_rdata
);
  logic [bitWidth-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cnn_pixel_streamer.sv
// Ping-pong frame buffer feeding the CNN pixel input: frames are loaded over a
// valid/ready port and streamed out in raster order without stalls.
module cnn_pixel_streamer
  import cnn_stream_pkg::*;
#(
  parameter int bitWidth   = BIT_W,
  parameter int NFRAC      = FRAC_W,
  parameter int inputWidth = IN_W,
  parameter int gapCycles  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    streamEn,
  output logic                    loadErr,
  output logic [1:0]              bankFull,
  cnn_pixel_streamer_if.slave     bus
);
  localparam int NUM_PIX = inputWidth * inputWidth;
  localparam int AW      = idx_bits(NUM_PIX);
  localparam int GW      = idx_bits(gapCycles + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_PIX - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(gapCycles);

  if (NFRAC > bitWidth) begin : g_nfrac_range
    $error("NFRAC exceeds bitWidth");
  end

  // write side
  logic [AW-1:0] r_wrIdx;
  logic          r_wrBank;
  logic          r_loadErr;
  logic          w_wrReady;
  logic          w_accept;
  logic          w_commit;

  // read side
  stream_state_t r_state, w_nxtState;
  logic [AW-1:0] r_rdIdx, w_nxtRdIdx, w_emitIdx;
  logic          r_rdBank;
  logic [GW-1:0] r_gapCnt, w_nxtGap;
  logic [1:0]    r_bankFull;
  logic          w_startOk, w_emit, w_release;
  logic [1:0]    w_setMask, w_clrMask;

  logic [1:0][bitWidth-1:0] w_bankRd;
  logic [bitWidth-1:0]      w_rdData;

  logic [bitWidth-1:0] r_outPixel;
  logic                r_outValid, r_outFirst, r_outLast;

  assign w_wrReady = !r_bankFull[r_wrBank];
  assign w_accept  = bus.wrValid && w_wrReady;
  assign w_commit  = w_accept && (r_wrIdx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrIdx   <= '0;
      r_wrBank  <= 1'b0;
      r_loadErr <= 1'b0;
    end else if (w_accept) begin
      if (r_wrIdx == LAST_IDX) begin
        // a full-length frame commits even when wrLast is missing
        r_wrIdx  <= '0;
        r_wrBank <= ~r_wrBank;
        if (!bus.wrLast) r_loadErr <= 1'b1;
      end else if (bus.wrLast) begin
        r_wrIdx   <= '0;
        r_loadErr <= 1'b1;
      end else begin
        r_wrIdx <= r_wrIdx + 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pixel_bank #(
      .bitWidth (bitWidth),
      .DEPTH    (NUM_PIX),
      .AW       (AW)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_accept && (r_wrBank == 1'(b))),
      .i_waddr (r_wrIdx),
      .i_wdata (bus.wrPixel),
      .i_raddr (w_emitIdx),
      .o_rdata (w_bankRd[b])
    );
  end

  assign w_rdData  = w_bankRd[r_rdBank];
  assign w_startOk = r_bankFull[r_rdBank] && streamEn;

  // Starting a frame emits pixel 0 on the same edge that leaves IDLE/GAP, so
  // the first pixel follows the committing write by one clock.
  always_comb begin
    w_emit     = 1'b0;
    w_emitIdx  = r_rdIdx;
    w_nxtState = r_state;
    w_nxtRdIdx = r_rdIdx;
    w_nxtGap   = r_gapCnt;
    w_release  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_startOk) begin
          w_emit     = 1'b1;
          w_emitIdx  = '0;
          w_nxtRdIdx = AW'(1);
          w_nxtState = S_STREAM;
        end
      end
      S_STREAM: begin
        w_emit = 1'b1;
        if (r_rdIdx == LAST_IDX) begin
          w_release  = 1'b1;
          w_nxtRdIdx = '0;
          if (gapCycles > 0) begin
            w_nxtState = S_GAP;
            w_nxtGap   = '0;
          end else if (r_bankFull[~r_rdBank] && streamEn) begin
            w_nxtState = S_STREAM;
          end else begin
            w_nxtState = S_IDLE;
          end
        end else begin
          w_nxtRdIdx = r_rdIdx + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gapCnt == GAP_MAX) begin
          if (w_startOk) begin
            w_emit     = 1'b1;
            w_emitIdx  = '0;
            w_nxtRdIdx = AW'(1);
            w_nxtState = S_STREAM;
          end else begin
            w_nxtState = S_IDLE;
          end
        end else begin
          w_nxtGap = r_gapCnt + 1'b1;
        end
      end
      default: w_nxtState = S_IDLE;
    endcase
  end

  // commit and release always address different banks
  assign w_setMask = w_commit  ? (2'b01 << r_wrBank) : 2'b00;
  assign w_clrMask = w_release ? (2'b01 << r_rdBank) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rdIdx    <= '0;
      r_rdBank   <= 1'b0;
      r_gapCnt   <= '0;
      r_bankFull <= 2'b00;
      r_outPixel <= '0;
      r_outValid <= 1'b0;
      r_outFirst <= 1'b0;
      r_outLast  <= 1'b0;
    end else begin
      r_state    <= w_nxtState;
      r_rdIdx    <= w_nxtRdIdx;
      r_gapCnt   <= w_nxtGap;
      r_bankFull <= (r_bankFull | w_setMask) & ~w_clrMask;
      if (w_release) r_rdBank <= ~r_rdBank;
      r_outValid <= w_emit;
      r_outPixel <= w_emit ? w_rdData : '0;
      r_outFirst <= w_emit && (w_emitIdx == '0);
      r_outLast  <= w_emit && (w_emitIdx == LAST_IDX);
    end
  end

  assign bus.wrReady  = w_wrReady;
  assign bus.outPixel = r_outPixel;
  assign bus.outValid = r_outValid;
  assign bus.outFirst = r_outFirst;
  assign bus.outLast  = r_outLast;
  assign loadErr      = r_loadErr;
  assign bankFull     = r_bankFull;
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Directed bench for cnn_pixel_streamer: gapCycles=0 instance for most cases,
// gapCycles=3 instance for the inter-frame gap case.
module tb_cnn_pixel_streamer;
  logic       clk = 1'b0;
  logic       rst, se, sel, wv, wlast;
  logic [3:0] wpx;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  cnn_pixel_streamer_if #(.bitWidth(4)) bus0 ();
  cnn_pixel_streamer_if #(.bitWidth(4)) bus1 ();

  logic       err0, err1;
  logic [1:0] bf0, bf1;

  assign bus0.wrValid = wv && !sel;
  assign bus1.wrValid = wv && sel;
  assign bus0.wrPixel = wpx;
  assign bus1.wrPixel = wpx;
  assign bus0.wrLast  = wlast;
  assign bus1.wrLast  = wlast;

  cnn_pixel_streamer #(.bitWidth(4), .NFRAC(2), .inputWidth(8), .gapCycles(0)) u_dut0 (
    .clk(clk), .reset(rst), .streamEn(se), .loadErr(err0), .bankFull(bf0), .bus(bus0));
  cnn_pixel_streamer #(.bitWidth(4), .NFRAC(2), .inputWidth(8), .gapCycles(3)) u_dut1 (
    .clk(clk), .reset(rst), .streamEn(se), .loadErr(err1), .bankFull(bf1), .bus(bus1));

  logic       o_vld, o_first, o_last, o_rdy, o_err;
  logic [3:0] o_px;
  logic [1:0] o_bf;
  assign o_vld   = sel ? bus1.outValid : bus0.outValid;
  assign o_first = sel ? bus1.outFirst : bus0.outFirst;
  assign o_last  = sel ? bus1.outLast  : bus0.outLast;
  assign o_px    = sel ? bus1.outPixel : bus0.outPixel;
  assign o_rdy   = sel ? bus1.wrReady  : bus0.wrReady;
  assign o_err   = sel ? err1 : err0;
  assign o_bf    = sel ? bf1  : bf0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wv  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr_px(input logic [3:0] d, input logic last);
    int w = 0;
    wpx = d; wlast = last; wv = 1'b1;
    while (!o_rdy) begin
      if (w >= 400) begin
        chk("wr_ready_tmo", 32'd0, 32'd1);
        wv = 1'b0;
        return;
      end
      step();
      w++;
    end
    step();
    wv = 1'b0; wlast = 1'b0;
  endtask

  task automatic wr_frame(input int off, input int last_at, input bit no_last);
    for (int i = 0; i <= last_at; i++) begin
      logic [3:0] d;
      d = 4'(i + off);
      wr_px(d, (i == last_at) && !no_last);
    end
  endtask

  // frame f pixel i is expected to be (i + off_f) mod 16
  task automatic chk_stream(input string tag, input int nfr, input int gap, input int budget,
                            input int o0, input int o1, input int o2);
    int w = 0;
    int offs [3];
    offs[0] = o0; offs[1] = o1; offs[2] = o2;
    while (!o_vld) begin
      if (w >= budget) begin
        chk({tag, "_start_tmo"}, 32'd0, 32'd1);
        return;
      end
      step();
      w++;
    end
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < 64; i++) begin
        logic [3:0] d;
        d = 4'(i + offs[f]);
        chk(tag, 32'({o_vld, o_first, o_last, o_px}), 32'({1'b1, i == 0, i == 63, d}));
        step();
      end
      if (f < nfr - 1)
        for (int g = 0; g < gap; g++) begin
          chk({tag, "_gap"}, 32'(o_vld), 32'd0);
          step();
        end
    end
    chk({tag, "_end"}, 32'(o_vld), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; se = 1'b0; wv = 1'b0; wlast = 1'b0; wpx = 4'd0;
    do_reset();
    chk("rst_vld",   32'(o_vld), 32'd0);
    chk("rst_px",    32'(o_px),  32'd0);
    chk("rst_flags", 32'({o_first, o_last}), 32'd0);
    chk("rst_bf",    32'(o_bf),  32'd0);
    chk("rst_rdy",   32'(o_rdy), 32'd1);
    chk("rst_err",   32'(o_err), 32'd0);

    // single frame, pixel 0 one clock after the last accept
    se = 1'b1;
    wr_frame(0, 63, 1'b0);
    chk("t1_bf_commit", 32'(o_bf), 32'd1);
    chk_stream("t1", 1, 0, 1, 0, 0, 0);
    chk("t1_err", 32'(o_err), 32'd0);
    chk("t1_bf_free", 32'(o_bf), 32'd0);

    // two frames back to back, 128 contiguous pixels
    fork
      begin wr_frame(0, 63, 1'b0); wr_frame(3, 63, 1'b0); end
      chk_stream("t2", 2, 0, 200, 0, 3, 0);
    join

    // both banks full, third frame stalls until bank 0 frees
    do_reset();
    se = 1'b0;
    wr_frame(5, 63, 1'b0);
    wr_frame(11, 63, 1'b0);
    fork
      wr_frame(13, 63, 1'b0);
      begin
        repeat (5) step();
        chk("t3_rdy_full", 32'(o_rdy), 32'd0);
        chk("t3_bf_full",  32'(o_bf),  32'd3);
        chk("t3_vld_held", 32'(o_vld), 32'd0);
        se = 1'b1;
        chk_stream("t3", 3, 0, 3, 5, 11, 13);
      end
      begin
        int w = 0;
        while (!o_last && w < 300) begin step(); w++; end
        chk("t3_rdy_at_last", 32'(o_rdy && o_last), 32'd1);
      end
    join
    chk("t3_err", 32'(o_err), 32'd0);

    // early wrLast discards the frame, the next frame is intact
    do_reset();
    se = 1'b1;
    wr_frame(0, 10, 1'b0);
    chk("t4_err", 32'(o_err), 32'd1);
    chk("t4_bf_none", 32'(o_bf), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_no_vld", 32'(o_vld), 32'd0);
    end
    wr_frame(7, 63, 1'b0);
    chk("t4_bf_bank0", 32'(o_bf), 32'd1);
    chk_stream("t4", 1, 0, 1, 7, 0, 0);
    chk("t4_err_sticky", 32'(o_err), 32'd1);

    // reset while streaming pixel 20
    do_reset();
    chk("t5_err_clr", 32'(o_err), 32'd0);
    wr_frame(2, 63, 1'b0);
    step();
    repeat (20) step();
    chk("t5_px20", 32'({o_vld, o_first, o_last, o_px}), 32'({1'b1, 1'b0, 1'b0, 4'd6}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_vld", 32'(o_vld), 32'd0);
    chk("t5_rst_bf",  32'(o_bf),  32'd0);
    chk("t5_rst_rdy", 32'(o_rdy), 32'd1);
    step();
    chk("t5_idle_vld", 32'(o_vld), 32'd0);
    wr_frame(9, 63, 1'b0);
    chk_stream("t5", 1, 0, 1, 9, 0, 0);

    // missing wrLast on the final pixel: flagged but still committed
    do_reset();
    wr_frame(4, 63, 1'b1);
    chk("t6_err", 32'(o_err), 32'd1);
    chk("t6_bf",  32'(o_bf),  32'd1);
    chk_stream("t6", 1, 0, 1, 4, 0, 0);

    // gapCycles=3 instance: three idle cycles between frames
    se  = 1'b0;
    sel = 1'b1;
    do_reset();
    wr_frame(1, 63, 1'b0);
    wr_frame(6, 63, 1'b0);
    chk("t7_bf", 32'(o_bf), 32'd3);
    se = 1'b1;
    chk_stream("t7", 2, 3, 3, 1, 6, 0);
    chk("t7_err", 32'(o_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cnn_pixel_streamer.md
Name: cnn_pixel_streamer

Overview:
Source-side feeder for the 2D CNN pixel input. It accepts whole frames of inputWidth x inputWidth signed fixed-point pixels over a valid/ready write port into two ping-pong banks. It streams committed frames out in raster order, one pixel per clock with no stalls, because the CNN input has no backpressure. It also emits frame-boundary markers so downstream logic knows when the CNN output reflects a complete frame.

Parameters:
bitWidth, 4, pixel width in bits (signed, NFRAC fractional bits)
NFRAC, 2, fractional bits; carried for package typing only, no arithmetic performed
inputWidth, 8, frame side; frame holds NPIX = inputWidth**2 pixels
gapCycles, 0, idle cycles (outValid=0) inserted after each streamed frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wrValid  in  1  write pixel valid
wrReady  out  1  streamer can accept a write pixel
wrPixel  in  bitWidth  signed pixel, raster order
wrLast  in  1  marks the final pixel of a frame
streamEn  in  1  permits a new frame to start streaming
outPixel  out  bitWidth  signed pixel to the CNN inputPixel
outValid  out  1  outPixel is a live frame pixel
outFirst  out  1  high with pixel 0 of a frame
outLast  out  1  high with pixel NPIX-1 of a frame
loadErr  out  1  sticky framing-error flag
bankFull  out  2  per-bank committed flag (status)

Behaviour:
- Reset (synchronous, active-high):
  - wrIdx=0, wrBank=0, rdIdx=0, rdBank=0, bankFull=2'b00, FSM=S_IDLE, gap counter=0.
  - All outputs 0 except wrReady, which reads 1 on the cycle after reset because bankFull is 0.
  - Bank contents are not reset.
  - Reset mid-load or mid-stream drops the partial frame; the next cycle shows outValid=0.
- Write side:
  - wrReady = !bankFull[wrBank] (combinational from registers).
  - A pixel is accepted when wrValid && wrReady; it is stored at bank[wrBank][wrIdx], then wrIdx++.
  - Accept with wrIdx==NPIX-1: set bankFull[wrBank], toggle wrBank, wrIdx=0. If wrLast was low on that beat, set loadErr; the frame is still committed.
  - Accept with wrLast=1 and wrIdx<NPIX-1 (early last): discard the frame. wrIdx=0, bank not committed, wrBank unchanged, loadErr=1.
  - loadErr clears only on reset.
- Read FSM:
  - S_IDLE: if bankFull[rdBank] && streamEn, go to S_STREAM with rdIdx=0.
  - S_STREAM, each cycle:
    - Register outPixel=bank[rdBank][rdIdx] and outValid=1.
    - outFirst=(rdIdx==0); outLast=(rdIdx==NPIX-1).
    - rdIdx++.
  - S_STREAM at rdIdx==NPIX-1:
    - Clear bankFull[rdBank] and toggle rdBank.
    - If gapCycles>0, go to S_GAP.
    - Else, if the other bank is full and streamEn=1, stay in S_STREAM with rdIdx=0 (back-to-back, no bubble).
    - Else go to S_IDLE.
  - S_GAP: count gapCycles cycles, then evaluate the same start condition as S_IDLE.
  - streamEn is sampled only at frame start. Deasserting it mid-frame does not stall the stream.
- Outputs are registered. Whenever outValid=0: outPixel=0, outFirst=0, outLast=0.
- Latency: if the last write beat is accepted at edge t, pixel 0 appears after edge t+1 when streamEn=1 and the read side was idle.
- Simultaneous events:
  - A write commit and a read release in the same cycle target different banks and both take effect.
  - A bank freed at edge t shows wrReady=1 in the following cycle.
- Both banks full: wrReady=0 and writes stall indefinitely without loss.
- Widths: pixels pass bit-exact; no sign extension or rounding.
- Counters are $clog2(NPIX) bits wide and wrap only via the explicit reset-to-0 above.

Decomposition:
- Package cnn_stream_pkg:
  - typedef pixel_t (logic signed [bitWidth-1:0]).
  - localparam NPIX.
  - enum stream_state_t {S_IDLE, S_STREAM, S_GAP}.
- Sub-module pixel_bank: NPIX-entry register file with one write port (we, waddr, wdata) and one combinational read port. Instantiated twice.
- Top holds the write control, FSM and output registers.

Test Plan:
- Single frame, streamEn=1, pixel i=i[3:0] -> outValid high 64 consecutive cycles starting edge t+1 after the last accept. Values 0,1,…,7,-8,…,-1 repeating; outFirst on pixel 0, outLast on pixel 63, loadErr=0.
- Two frames loaded back-to-back, gapCycles=0 -> 128 contiguous outValid cycles, second outFirst immediately after first outLast.
- streamEn=0, attempt 3 frames -> wrReady drops after 128 accepts, bankFull=2'b11. Raise streamEn -> bank 0 streams; wrReady=1 the cycle after bank 0's outLast; frame 3 completes.
- Early wrLast at pixel 10, then a good frame -> loadErr=1, no outValid for the bad frame, good frame streams intact from bank 0.
- Reset asserted at streamed pixel 20 -> next cycle outValid=0, bankFull=0, wrReady=1; a new frame then streams correctly from pixel 0.
- gapCycles=3 with two queued frames -> exactly 3 cycles of outValid=0 between the first outLast and the second outFirst.
